// File: rtl/packet_sorter.sv
// rtl/packet_sorter.sv - HDMI data-island packet reassembly, BCH check and type dispatch
// Purpose: rebuilds 32-pixel data-island packets from the TERC4-decoded
//   per-pixel payload. It checks the BCH parity of the header and of each
//   subpacket, then dispatches ACR, AVI InfoFrame and audio sample packets.
// Ports:
//   clk_pixel, reset             pixel clock, synchronous active-high reset
//   packet_enable, packet_data   payload strobe and 9-bit per-pixel payload
//   packet_valid, header, sub    completion pulse and the completed packet
//   header_ok, sub_ok            BCH match flags for header / subpackets
//   acr_valid, acr_n, acr_cts    Audio Clock Regeneration update
//   avi_valid, avi_vic           AVI InfoFrame VIC update
//   sample_valid, sample_l/_r    audio sample pairs, one per cycle
//   ecc_error_count              saturating count of packets with BCH errors
module packet_sorter #(
   parameter int AUDIO_BIT_WIDTH = 16
) (
   input  logic                       clk_pixel,
   input  logic                       reset,
   input  logic                       packet_enable,
   input  logic [8:0]                 packet_data,
   output logic                       packet_valid,
   output logic [23:0]                header,
   output logic [3:0][55:0]           sub,
   output logic                       header_ok,
   output logic [3:0]                 sub_ok,
   output logic                       acr_valid,
   output logic [19:0]                acr_n,
   output logic [19:0]                acr_cts,
   output logic                       avi_valid,
   output logic [6:0]                 avi_vic,
   output logic                       sample_valid,
   output logic [AUDIO_BIT_WIDTH-1:0] sample_l,
   output logic [AUDIO_BIT_WIDTH-1:0] sample_r,
   output logic [15:0]                ecc_error_count
);

   localparam int W = AUDIO_BIT_WIDTH;

   // BCH(64,56) remainder over the first n bits of d, LSB first.
   function automatic logic [7:0] bch8(input logic [55:0] d, input int n);
      logic [7:0] e;
      e = 8'h00;
      for (int i = 0; i < 56; i++) begin
         if (i < n) e = (e >> 1) ^ ((e[0] ^ d[i]) ? 8'h83 : 8'h00);
      end
      return e;
   endfunction

   logic [4:0]        cnt_q, cnt_d;
   // Right-shifting capture: after 31 enabled pixels, pixel i sits at bit i
   // (header) or bits 2i+1:2i (subpackets); pixel 31 is taken live.
   logic [30:0]       hdr_sr_q;
   logic [3:0][61:0]  sub_sr_q;

   logic              pkt_done;
   logic [31:0]       hdr_full;
   logic [3:0][63:0]  sub_full;
   logic              hdr_ok_c;
   logic [3:0]        sub_ok_c;

   logic              packet_valid_q;
   logic [23:0]       header_q;
   logic [3:0][55:0]  sub_q;
   logic              header_ok_q;
   logic [3:0]        sub_ok_q;
   logic [15:0]       err_cnt_q, err_cnt_d;

   logic              acr_valid_q, avi_valid_q;
   logic [19:0]       acr_n_q, acr_cts_q;
   logic [6:0]        avi_vic_q;

   logic [3:0]        pend_q, pend_d, pend_src;
   logic              sample_valid_q, samp_fire;
   logic [1:0]        k_sel;
   logic [W-1:0]      sample_l_q, sample_r_q, samp_l_d, samp_r_d;

   logic [7:0]        hb0, hb1, hb2, csum;
   logic              disp, acr_hit, avi_hit;

   // Packet completion and parity check on the fully assembled packet.
   always_comb begin
      pkt_done = packet_enable && (cnt_q == 5'd31);
      cnt_d    = packet_enable ? cnt_q + 5'd1 : 5'd0;
      hdr_full = {packet_data[0], hdr_sr_q};
      hdr_ok_c = (bch8({32'h0, hdr_full[23:0]}, 24) == hdr_full[31:24]);
      for (int k = 0; k < 4; k++) begin
         sub_full[k] = {packet_data[5+k], packet_data[1+k], sub_sr_q[k]};
         sub_ok_c[k] = (bch8(sub_full[k][55:0], 56) == sub_full[k][63:56]);
      end
      err_cnt_d = err_cnt_q;
      if (pkt_done && (!hdr_ok_c || (sub_ok_c != 4'hF)) && (err_cnt_q != 16'hFFFF))
         err_cnt_d = err_cnt_q + 16'd1;
   end

   // Dispatch decisions taken in the packet_valid cycle from the held packet.
   always_comb begin
      hb0  = header_q[7:0];
      hb1  = header_q[15:8];
      hb2  = header_q[23:16];
      csum = hb0 + hb1 + hb2;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 7; j++) csum = csum + sub_q[k][8*j +: 8];
      end
      disp    = packet_valid_q && header_ok_q;
      acr_hit = disp && (hb0 == 8'h01) && sub_ok_q[0];
      avi_hit = disp && (hb0 == 8'h82) && (&sub_ok_q) && (hb1 == 8'h02)
                && (csum == 8'h00);

      pend_src = pend_q;
      if (disp && (hb0 == 8'h02)) pend_src = header_q[11:8] & sub_ok_q;

      // Lowest pending subpacket goes out first.
      samp_fire = 1'b0;
      k_sel     = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (pend_src[k]) begin
            samp_fire = 1'b1;
            k_sel     = 2'(k);
         end
      end
      pend_d = pend_src;
      if (samp_fire) pend_d[k_sel] = 1'b0;
      samp_l_d = sub_q[k_sel][23 -: W];
      samp_r_d = sub_q[k_sel][47 -: W];
   end

   always_ff @(posedge clk_pixel) begin
      if (packet_enable) begin
         hdr_sr_q <= {packet_data[0], hdr_sr_q[30:1]};
         for (int k = 0; k < 4; k++)
            sub_sr_q[k] <= {packet_data[5+k], packet_data[1+k], sub_sr_q[k][61:2]};
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         cnt_q          <= '0;
         packet_valid_q <= 1'b0;
         header_q       <= '0;
         sub_q          <= '0;
         header_ok_q    <= 1'b0;
         sub_ok_q       <= '0;
         err_cnt_q      <= '0;
         acr_valid_q    <= 1'b0;
         acr_n_q        <= '0;
         acr_cts_q      <= '0;
         avi_valid_q    <= 1'b0;
         avi_vic_q      <= '0;
         pend_q         <= '0;
         sample_valid_q <= 1'b0;
         sample_l_q     <= '0;
         sample_r_q     <= '0;
      end else begin
         cnt_q          <= cnt_d;
         packet_valid_q <= pkt_done;
         if (pkt_done) begin
            header_q    <= hdr_full[23:0];
            for (int k = 0; k < 4; k++) sub_q[k] <= sub_full[k][55:0];
            header_ok_q <= hdr_ok_c;
            sub_ok_q    <= sub_ok_c;
         end
         err_cnt_q   <= err_cnt_d;
         acr_valid_q <= acr_hit;
         if (acr_hit) begin
            acr_cts_q <= {sub_q[0][11:8], sub_q[0][23:16], sub_q[0][31:24]};
            acr_n_q   <= {sub_q[0][35:32], sub_q[0][47:40], sub_q[0][55:48]};
         end
         avi_valid_q <= avi_hit;
         if (avi_hit) avi_vic_q <= sub_q[0][38:32];
         pend_q         <= pend_d;
         sample_valid_q <= samp_fire;
         if (samp_fire) begin
            sample_l_q <= samp_l_d;
            sample_r_q <= samp_r_d;
         end
      end
   end

   assign packet_valid    = packet_valid_q;
   assign header          = header_q;
   assign sub             = sub_q;
   assign header_ok       = header_ok_q;
   assign sub_ok          = sub_ok_q;
   assign acr_valid       = acr_valid_q;
   assign acr_n           = acr_n_q;
   assign acr_cts         = acr_cts_q;
   assign avi_valid       = avi_valid_q;
   assign avi_vic         = avi_vic_q;
   assign sample_valid    = sample_valid_q;
   assign sample_l        = sample_l_q;
   assign sample_r        = sample_r_q;
   assign ecc_error_count = err_cnt_q;

endmodule

// File: doc/packet_sorter.md
# packet_sorter

Receive-side counterpart of the HDMI packet selection and assembly path. The block takes the 9-bit per-pixel data-island payload recovered after TERC4 decoding and rebuilds each 32-pixel packet: the header and four subpackets. It checks the BCH parity of every block and dispatches the packet by type. Audio Clock Regeneration values, AVI InfoFrame VIC and audio samples are presented to downstream audio and video logic.

## Interface
Parameters:
- AUDIO_BIT_WIDTH, 16: output sample width (1–24). Samples are the MSBs of the 24-bit IEC 60958 word.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- packet_enable  in  1  high for each pixel carrying data-island packet payload.
- packet_data  in  9  per-pixel payload: bit 0 = header bit; bits 4:1 = ch1 bits, one per subpacket k; bits 8:5 = ch2 bits, one per subpacket k.
- packet_valid  out  1  one-cycle pulse: packet complete.
- header  out  24  HB2:HB1:HB0, with HB0 = bits 7:0.
- sub  out  4×56  subpacket data, SB0 = bits 7:0.
- header_ok  out  1  header BCH matched.
- sub_ok  out  4  per-subpacket BCH matched.
- acr_valid  out  1  pulse; acr_n and acr_cts updated.
- acr_n  out  20  N value.
- acr_cts  out  20  CTS value.
- avi_valid  out  1  pulse; avi_vic updated.
- avi_vic  out  7  Video Identification Code.
- sample_valid  out  1  pulse per audio sample pair.
- sample_l  out  AUDIO_BIT_WIDTH  left sample.
- sample_r  out  AUDIO_BIT_WIDTH  right sample.
- ecc_error_count  out  16  saturating count of packets with any BCH mismatch.

## Operation
- Pixel counter (5 bit):
  - Increments on each cycle with packet_enable high and wraps 31→0, so back-to-back packets need no gap.
  - Clears to 0 on any cycle with packet_enable low; a partial packet is discarded silently.
- Pixel i (counter value i) captures its bits as follows:
  - header shift bit i ← packet_data[0].
  - For subpacket k: bit 2i ← packet_data[1+k] and bit 2i+1 ← packet_data[5+k].
  - Header bits 31:24 and subpacket bits 63:56 are the received parity bytes.
- BCH check, detection only with no correction:
  - Generator x^8+x^7+x^6+1. Register init 0, data taken LSB first.
  - Per bit: ecc ← (ecc>>1) ^ ((ecc[0]^bit) ? 8'h83 : 0).
  - Run over 24 header bits and over 56 bits per subpacket. A block is ok iff the computed ecc equals the received parity byte.
  - The computation runs serially alongside capture (the header ECC needs 1 bit/cycle, each subpacket 2 bits/cycle) or combinationally at completion; the result is identical either way.
- Dispatch happens in the cycle after packet_valid, and only when header_ok=1. Packet type is HB0:
  - 0x01 ACR, applied if sub_ok[0]:
    - acr_cts = {SB1[3:0],SB2,SB3}.
    - acr_n = {SB4[3:0],SB5,SB6} of subpacket 0.
  - 0x02 Audio Sample:
    - Present mask = HB1[3:0].
    - Subpacket k is eligible iff present[k] && sub_ok[k].
    - Its left word is sub[k][23:0] and its right word is sub[k][47:24]. Outputs carry the upper AUDIO_BIT_WIDTH bits of each.
    - Eligible subpackets are queued in ascending k and emitted one per cycle.
  - 0x82 AVI InfoFrame, applied iff all sub_ok, HB1=0x02, and the byte checksum is valid:
    - Checksum: HB0+HB1+HB2+PB0..PB27 ≡ 0 mod 256, where PB(7k+j) = SB j of subpacket k.
    - avi_vic = PB4[6:0].
  - Any other type, including 0x00 null: no dispatch.
- ecc_error_count increments by 1 per completed packet with !header_ok or any !sub_ok, and saturates at 0xFFFF.
- reset:
  - Clears the counter, all pulses, the sample queue and ecc_error_count.
  - Zeroes header, sub, header_ok, sub_ok, acr_n, acr_cts, avi_vic, sample_l and sample_r.
  - A packet in flight or a queue mid-drain is dropped.

## Timing
- Pixel 31 is captured in cycle t. packet_valid=1 in t+1 with header, sub, header_ok and sub_ok stable; these hold until the next packet_valid.
- acr_valid or avi_valid pulses in t+2 with new values, which hold until the next update.
- Audio samples appear in t+2 … t+1+n for n eligible subpackets (n ≤ 4), consecutive cycles with no gaps.
- The next packet completes no earlier than t+32, so the queue never overflows.
- A packet_enable drop mid-packet after a completed packet does not affect that packet's pending dispatch or drain.
- If reset is asserted during a drain, no further sample_valid pulses occur from cycle reset+1.

## Test plan
- ACR packet with N=6144, CTS=74250 and valid parity → packet_valid at t+1 with header_ok=1 and sub_ok=4'hF; acr_valid at t+2 with acr_n=6144 and acr_cts=74250.
- Audio sample packet with HB1[3:0]=4'b1011 and samples L/R = 0x123456/0xABCDEF (AUDIO_BIT_WIDTH=16) → 3 consecutive sample_valid pulses at t+2..t+4 in order k=0,1,3, with sample_l=0x1234 and sample_r=0xABCD for the first.
- AVI InfoFrame for VIC 16 with a correct checksum → avi_valid with avi_vic=16. Same packet with PB0 corrupted (BCH recomputed to match) → no avi_valid.
- Audio sample packet with one bit of subpacket 2 flipped → sub_ok=4'b1011, sample 2 suppressed, ecc_error_count +1. Flipped header bit → header_ok=0 and no dispatch.
- packet_enable drops at pixel 17, then a full null packet follows → exactly one packet_valid, for the null packet, and no dispatch.
- Two back-to-back packets with continuous enable, then reset at the first sample_valid → remaining samples suppressed and all outputs zero at reset+1.
